// File: rtl/mem_read_responder_if.sv
// Request/response bundle between the cache fill logic and mem_read_responder.
// The master issues reads/writes; the slave returns read data with a valid strobe.
interface mem_read_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] data_addr;
  logic              data_valid;
  logic              busy;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_addr, data_valid, busy
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_addr, data_valid, busy
  );
endinterface

// File: rtl/mem_read_responder.sv
// Word-addressed backing store with a fixed-latency, fully pipelined read path.
// One request per cycle; read responses return in order LATENCY edges after issue.
module mem_read_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_read_responder_if.slave  bus
);
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } stage_t;

  logic [DATA_W-1:0] store [MEM_WORDS];
  stage_t            pipe  [LATENCY];

  logic              rd_req;
  logic              wr_req;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] word_addr;
  logic              busy_c;

  // wr is only qualified by enable, so an undefined wr on idle cycles is harmless
  assign rd_req    = bus.enable & ~bus.wr;
  assign wr_req    = bus.enable &  bus.wr;
  assign idx       = IDX_W'(32'(bus.addr[ADDR_W-1:1]) % MEM_WORDS);
  assign word_addr = {bus.addr[ADDR_W-1:1], 1'b0};

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      store[idx] <= bus.data_in;
    end
  end

  // Stage 0 captures the pre-write store contents at the issue edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].valid <= rd_req;
      if (rd_req) begin
        pipe[0].data <= store[idx];
        pipe[0].addr <= word_addr;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      busy_c = busy_c | pipe[i].valid;
    end
  end

  assign bus.data_valid = pipe[LATENCY-1].valid;
  assign bus.data_out   = pipe[LATENCY-1].data;
  assign bus.data_addr  = pipe[LATENCY-1].addr;
  assign bus.busy       = busy_c;
endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: reads are scored against a memory
// model and an expected-response queue checked every cycle.
module tb_mem_read_responder;
  localparam int unsigned LAT = 4;
  localparam int unsigned MW  = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_read_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_read_responder #(
    .LATENCY  (LAT),
    .ADDR_W   (16),
    .DATA_W   (16),
    .MEM_WORDS(MW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] model [MW];
  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int unsigned widx(input logic [15:0] a);
    return int'(a[15:1]) % MW;
  endfunction

  // One request per rising edge; expectations derive from the model before any write.
  task automatic op(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.enable  = en;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
    if (en && !w) sb.push_back('{due: edge_n + LAT - 1, data: model[widx(a)], addr: {a[15:1], 1'b0}});
    if (en && w) model[widx(a)] = d;
    bus.enable  = 1'b0;
    bus.wr      = 1'b1;
    bus.addr    = 16'($urandom);
    bus.data_in = 16'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) op(1'b0, 1'b1, 16'h0000, 16'h0000);
  endtask

  // Response monitor: compares DUT outputs against the queue head once per cycle.
  always @(negedge clk) begin : monitor
    logic exp_v;
    exp_t e;
    if (rst_n) begin
      if (sb.size() > 0) begin
        checks++;
        assert (sb[0].due >= edge_n)
        else begin
          errors++;
          $error("FAIL missed_response edge=%0d observed_due=%0d expected_due>=%0d", edge_n, sb[0].due, edge_n);
          void'(sb.pop_front());
        end
      end
      exp_v = (sb.size() > 0) && (sb[0].due == edge_n);
      checks++;
      assert (bus.data_valid === exp_v)
      else begin
        errors++;
        $error("FAIL data_valid edge=%0d observed=%b expected=%b", edge_n, bus.data_valid, exp_v);
      end
      checks++;
      assert (bus.busy === (sb.size() > 0))
      else begin
        errors++;
        $error("FAIL busy edge=%0d observed=%b expected=%b", edge_n, bus.busy, sb.size() > 0);
      end
      if (exp_v) begin
        e = sb.pop_front();
        checks++;
        assert (bus.data_out === e.data)
        else begin
          errors++;
          $error("FAIL data_out edge=%0d observed=%h expected=%h", edge_n, bus.data_out, e.data);
        end
        checks++;
        assert (bus.data_addr === e.addr)
        else begin
          errors++;
          $error("FAIL data_addr edge=%0d observed=%h expected=%h", edge_n, bus.data_addr, e.addr);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    checks++;
    assert (bus.data_valid === 1'b0 && bus.busy === 1'b0 && bus.data_out === 16'h0000 && bus.data_addr === 16'h0000)
    else begin
      errors++;
      $error("FAIL %s observed valid=%b busy=%b data=%h addr=%h expected all zero",
             tag, bus.data_valid, bus.busy, bus.data_out, bus.data_addr);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    #3;
    check_idle_outputs("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Preload every word with a known pattern
    for (int unsigned i = 0; i < MW; i++) op(1'b1, 1'b1, 16'(i * 2), 16'h5A00 ^ 16'(i * 37));
    idle(2);

    // Single read of word 8
    op(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(LAT + 1);

    // Write then immediate read of the same word
    op(1'b1, 1'b1, 16'h0020, 16'hBEEF);
    op(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(LAT + 1);

    // Eight-word block fill streams back without bubbles
    for (int unsigned i = 0; i < 8; i++) op(1'b1, 1'b0, 16'h0100 + 16'(i * 2), 16'h0000);
    idle(LAT + 2);

    // Odd byte address aligns down; out-of-range addresses wrap modulo store size
    op(1'b1, 1'b0, 16'h0031, 16'h0000);
    op(1'b1, 1'b0, 16'h0030, 16'h0000);
    op(1'b1, 1'b0, 16'h0810, 16'h0000);
    op(1'b1, 1'b1, 16'hFFFE, 16'h1234);
    op(1'b1, 1'b0, 16'h07FE, 16'h0000);
    idle(LAT + 1);

    // Read / write / read on one word gives old then new data with a bubble
    op(1'b1, 1'b0, 16'h0040, 16'h0000);
    op(1'b1, 1'b1, 16'h0040, 16'hC0DE);
    op(1'b1, 1'b0, 16'h0040, 16'h0000);
    idle(LAT + 1);

    // Reset mid-fill: assert during the second response's valid cycle
    op(1'b1, 1'b0, 16'h0050, 16'h0000);
    op(1'b1, 1'b0, 16'h0052, 16'h0000);
    op(1'b1, 1'b0, 16'h0054, 16'h0000);
    idle(LAT - 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset_drop");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 2);
    op(1'b1, 1'b0, 16'h0020, 16'h0000);
    op(1'b1, 1'b0, 16'h0052, 16'h0000);
    idle(LAT + 2);

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL drain observed_pending=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
